// File: rtl/found_frame_arbiter.sv
// Round-robin arbiter that serialises one module's tap buffer at a time as a
// framed byte stream (header, optional index, taps, optional XOR checksum).
module found_frame_arbiter #(
  parameter int         NUM_OF_TAPS    = 5,
  parameter int         NUM_OF_MODULES = 20,
  parameter logic [7:0] HEADER         = 8'hFF,
  parameter bit         SEND_INDEX     = 1'b1,
  parameter bit         SEND_CHECKSUM  = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_OF_MODULES*NUM_OF_TAPS*8-1:0] co_buf,
  input  logic [NUM_OF_MODULES-1:0]               found,
  output logic [NUM_OF_MODULES-1:0]               ack,
  output logic [7:0]                              tx_data,
  output logic                                    tx_valid,
  input  logic                                    tx_ready,
  output logic                                    busy,
  output logic [15:0]                             frames_sent,
  output logic [15:0]                             frames_dropped
);

  localparam int TW        = NUM_OF_TAPS * 8;
  localparam int SEL_W     = (NUM_OF_MODULES > 1) ? $clog2(NUM_OF_MODULES) : 1;
  localparam int FRAME_LEN = 1 + int'(SEND_INDEX) + NUM_OF_TAPS + int'(SEND_CHECKSUM);
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {IDLE, CHECK, SEND, ACK} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d, rr_ptr_q, rr_ptr_d, pick, cand;
  logic              pick_vld;
  int                idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dropped_q, dropped_d;
  logic [15:0]       sent_q, sent_d, drop_cnt_q, drop_cnt_d;
  logic [TW-1:0]     snap_q, snap_d;
  logic [7:0]        idx_byte, csum, frame_byte;
  int                tap_pos;

  // Scan downwards so the candidate closest after rr_ptr is the last to win.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int i = NUM_OF_MODULES; i >= 1; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_OF_MODULES) idx = idx - NUM_OF_MODULES;
      cand = SEL_W'(idx);
      if (found[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    snap_d = snap_q;
    if (state_q == IDLE && pick_vld) begin
      for (int m = 0; m < NUM_OF_MODULES; m++) begin
        if (pick == SEL_W'(m)) snap_d = co_buf[m*TW +: TW];
      end
    end
  end

  always_comb begin
    idx_byte = 8'(sel_q);
    csum     = SEND_INDEX ? idx_byte : 8'h00;
    for (int k = 0; k < NUM_OF_TAPS; k++) csum = csum ^ snap_q[k*8 +: 8];
  end

  // Frame position cnt maps to header, index, tap k, then checksum.
  always_comb begin
    tap_pos    = int'(cnt_q) - 1 - int'(SEND_INDEX);
    frame_byte = csum;
    if (cnt_q == '0) begin
      frame_byte = HEADER;
    end else if (SEND_INDEX && cnt_q == CNT_W'(1)) begin
      frame_byte = idx_byte;
    end else begin
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        if (tap_pos == k) frame_byte = snap_q[k*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    dropped_d  = dropped_q;
    sent_d     = sent_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d   = pick;
          state_d = CHECK;
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (snap_q[7:0] == 8'h00) begin
          dropped_d = 1'b1;
          state_d   = ACK;
        end else begin
          dropped_d = 1'b0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (int'(cnt_q) == FRAME_LEN - 1) state_d = ACK;
          else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        rr_ptr_d = sel_q;
        state_d  = IDLE;
        if (dropped_q) drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
        else           sent_d     = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= SEL_W'(NUM_OF_MODULES - 1);
      cnt_q      <= '0;
      dropped_q  <= 1'b0;
      sent_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      dropped_q  <= dropped_d;
      sent_q     <= sent_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  always_comb begin
    ack = '0;
    if (state_q == ACK) ack[sel_q] = 1'b1;
  end

  assign tx_valid       = (state_q == SEND);
  assign tx_data        = (state_q == SEND) ? frame_byte : 8'h00;
  assign busy           = (state_q != IDLE);
  assign frames_sent    = sent_q;
  assign frames_dropped = drop_cnt_q;

endmodule

// File: doc/found_frame_arbiter.md
Name: found_frame_arbiter

Overview:
- Collects "found" reports from NUM_OF_MODULES search modules, each with a NUM_OF_TAPS-byte tap buffer.
- Grants one module at a time with round-robin arbitration and serialises its buffer as a framed byte stream over a valid/ready byte interface; the stream feeds the RS232 transmitter.
- Acknowledges each served or dropped module with a one-cycle ack pulse.
- Successor to the single-winner found/UART interface: adds fair arbitration, optional index and checksum bytes, backpressure-safe handshaking and statistics counters.

Parameters:
- NUM_OF_TAPS, 5: bytes per module tap buffer (1..32).
- NUM_OF_MODULES, 20: number of reporting modules (1..256).
- HEADER, 8'hFF: first byte of every frame.
- SEND_INDEX, 1: 1 = module index byte follows the header.
- SEND_CHECKSUM, 1: 1 = XOR checksum byte ends the frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- co_buf  in  NUM_OF_MODULES*NUM_OF_TAPS*8  concatenated tap buffers; module m occupies bits [(m+1)*NUM_OF_TAPS*8-1 : m*NUM_OF_TAPS*8]
- found  in  NUM_OF_MODULES  per-module report request, level
- ack  out  NUM_OF_MODULES  one-cycle "report consumed" pulse, one-hot
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in any state other than IDLE
- frames_sent  out  16  completed frames, saturating
- frames_dropped  out  16  dropped (zero) reports, saturating

Behaviour:
- Reset, asynchronous, effective immediately including mid-frame:
  - ack=0, tx_valid=0, tx_data=0, busy=0, both counters=0, state=IDLE.
  - rr_ptr=NUM_OF_MODULES-1, so the first search starts at module 0.
- States: IDLE, CHECK, SEND, ACK.
- IDLE, when found!=0:
  - Select the first set found bit scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_OF_MODULES.
  - Register sel and snapshot that module's co_buf slice in the same edge; go to CHECK.
  - Later co_buf changes do not affect the frame.
- CHECK (1 cycle):
  - If snapshot byte 0 ([7:0]) == 0, go to ACK marked "dropped".
  - Else go to SEND with byte count=0.
- Frame layout, frame length L = 1 + SEND_INDEX + NUM_OF_TAPS + SEND_CHECKSUM:
  - HEADER.
  - [sel zero-extended to 8 bits].
  - Tap bytes 0..NUM_OF_TAPS-1, where byte k = snapshot[8k+7:8k].
  - [checksum = XOR of the index byte (if sent) and all tap bytes; the header is excluded].
- SEND handshake:
  - tx_valid=1 with tx_data = frame byte[count].
  - A byte transfers on a cycle where tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data holds stable and tx_valid stays high.
  - Count increments per transfer; the next byte is presented the cycle after a transfer, with no gap required.
  - Transfer of byte L-1 → tx_valid=0 next cycle, go to ACK.
- ACK (1 cycle):
  - ack[sel]=1 and all other ack bits 0.
  - frames_sent+1 if the frame was sent, frames_dropped+1 if dropped; both saturate at 16'hFFFF.
  - rr_ptr=sel; go to IDLE.
- Modules deassert found within 1 cycle of ack.
  - A found still high in the following IDLE is treated as a new report; round-robin ordering still favours the other requesters.
- found bits rising during CHECK/SEND/ACK are held by the requester and served later; nothing is lost.
- Minimum report-to-report spacing: IDLE→CHECK→SEND(L cycles at full ready)→ACK→IDLE = L+3 cycles.

Test Plan:
- NUM_OF_TAPS=5, module 3 found, buffer 40'h0504030201, tx_ready=1 → bytes FF,03,01,02,03,04,05,02 on consecutive cycles; ack[3] pulses 1 cycle after the last transfer; frames_sent=1.
- found[2] and found[7] set together, each re-asserted after its ack → service order 2,7,2,7; index bytes 02,07,02,07.
- Module 5 buffer byte0=0x00 → tx_valid never rises; ack[5] pulses 2 cycles after the IDLE grant; frames_dropped=1, frames_sent unchanged.
- tx_ready held low 10 cycles on the third byte → tx_data constant 0x01 and tx_valid high throughout; the frame completes unaltered after release.
- rst_n low while the fourth byte is pending → tx_valid, busy and counters reach 0 immediately; after release, a pending found[0] yields a full fresh frame starting with FF.
- SEND_INDEX=0, SEND_CHECKSUM=0, buffer 40'h0504030201 → exactly 6 bytes FF,01,02,03,04,05.
